// File: rtl/fetch_stage_if.sv
// Fetch-stage control, instruction-memory and IF/ID signal bundle.
// Optional macro FETCH_REDIRECT_COUNT_EN adds the redirect_count output.
interface fetch_stage_if;
    logic        halt;
    logic        if_flush;
    logic        pc_op;
    logic        b_jmp;
    logic        stall;
    logic [15:0] branch_target;
    logic [15:0] jump_target;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic [15:0] if_id_instr;
    logic [15:0] if_id_pc2;
    logic        if_id_valid;
    logic        halted;
`ifdef FETCH_REDIRECT_COUNT_EN
    logic [15:0] redirect_count;

    modport master (
        output halt, if_flush, pc_op, b_jmp, stall, branch_target, jump_target, imem_rdata,
        input  imem_addr, if_id_instr, if_id_pc2, if_id_valid, halted, redirect_count
    );

    modport slave (
        input  halt, if_flush, pc_op, b_jmp, stall, branch_target, jump_target, imem_rdata,
        output imem_addr, if_id_instr, if_id_pc2, if_id_valid, halted, redirect_count
    );
`else
    modport master (
        output halt, if_flush, pc_op, b_jmp, stall, branch_target, jump_target, imem_rdata,
        input  imem_addr, if_id_instr, if_id_pc2, if_id_valid, halted
    );

    modport slave (
        input  halt, if_flush, pc_op, b_jmp, stall, branch_target, jump_target, imem_rdata,
        output imem_addr, if_id_instr, if_id_pc2, if_id_valid, halted
    );
`endif
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, RUN/HALTED control and IF/ID pipeline register.
// Optional macro FETCH_REDIRECT_COUNT_EN adds a 16-bit count of accepted PC redirects.
module fetch_stage (
    input logic          clk,
    input logic          reset,
    fetch_stage_if.slave bus
);

    typedef enum logic [0:0] {StRun, StHalted} state_e;

    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] pc2_q, pc2_d;
    logic        valid_q, valid_d;
    logic [15:0] pc_plus2;
    logic [15:0] redirect_target;
    logic        redirect_accept;

    assign pc_plus2        = pc_q + 16'd2;
    // Instructions are halfword aligned, so a redirect never lands on an odd byte.
    assign redirect_target = (bus.b_jmp ? bus.branch_target : bus.jump_target) & 16'hFFFE;

    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        instr_d         = instr_q;
        pc2_d           = pc2_q;
        valid_d         = valid_q;
        redirect_accept = 1'b0;
        unique case (state_q)
            StRun: begin
                if (bus.halt) begin
                    state_d = StHalted;
                    instr_d = 16'h0000;
                    pc2_d   = 16'h0000;
                    valid_d = 1'b0;
                end else if (bus.pc_op) begin
                    pc_d            = redirect_target;
                    instr_d         = 16'h0000;
                    pc2_d           = 16'h0000;
                    valid_d         = 1'b0;
                    redirect_accept = 1'b1;
                end else if (bus.if_flush) begin
                    pc_d    = pc_plus2;
                    instr_d = 16'h0000;
                    pc2_d   = 16'h0000;
                    valid_d = 1'b0;
                end else if (!bus.stall) begin
                    pc_d    = pc_plus2;
                    instr_d = bus.imem_rdata;
                    pc2_d   = pc_plus2;
                    valid_d = 1'b1;
                end
            end
            StHalted: begin
                // Only reset leaves HALTED; everything holds.
            end
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StRun;
            pc_q    <= 16'h0000;
            instr_q <= 16'h0000;
            pc2_q   <= 16'h0000;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc2_q   <= pc2_d;
            valid_q <= valid_d;
        end
    end

    assign bus.imem_addr   = pc_q;
    assign bus.if_id_instr = instr_q;
    assign bus.if_id_pc2   = pc2_q;
    assign bus.if_id_valid = valid_q;
    assign bus.halted      = (state_q == StHalted);

`ifdef FETCH_REDIRECT_COUNT_EN
    logic [15:0] redirect_count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            redirect_count_q <= 16'h0000;
        end else if (redirect_accept) begin
            redirect_count_q <= redirect_count_q + 16'd1;
        end
    end

    assign bus.redirect_count = redirect_count_q;
`else
    logic unused_redirect_accept;
    assign unused_redirect_accept = redirect_accept;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: random control stimulus against a behavioural PC/IF-ID model.
module tb_fetch_stage;

    logic clk;
    logic reset;

    fetch_stage_if bus ();

    fetch_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] instr;
        logic [15:0] pc2;
        logic [15:0] cnt;
        logic        valid;
        logic        halted;
    } exp_t;

    exp_t sb_q[$];
    int   total;
    int   bad;

    // Reference model state.
    logic [15:0] m_pc, m_instr, m_pc2, m_cnt;
    logic        m_valid, m_halted;
    int          halted_cycles;

    function automatic logic [15:0] imem_f(input logic [15:0] a);
        if (a == 16'h0000) return 16'h1234;
        return {a[7:0], a[15:8]} ^ 16'h5A3C ^ {a[3:0], 12'h000};
    endfunction

    assign bus.imem_rdata = imem_f(bus.imem_addr);

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 16'h0000; m_instr = 16'h0000; m_pc2 = 16'h0000; m_cnt = 16'h0000;
        m_valid = 1'b0; m_halted = 1'b0;
    endtask

    task automatic set_idle();
        bus.halt = 1'b0; bus.if_flush = 1'b0; bus.pc_op = 1'b0; bus.b_jmp = 1'b0;
        bus.stall = 1'b0; bus.branch_target = 16'h0000; bus.jump_target = 16'h0000;
    endtask

    // One clock: drive inputs at the negedge, predict the post-edge view, queue it.
    task automatic step(input logic h, input logic fl, input logic po, input logic bj,
                        input logic st, input logic [15:0] bt, input logic [15:0] jt);
        exp_t e;
        logic [15:0] seq;
        bus.halt = h; bus.if_flush = fl; bus.pc_op = po; bus.b_jmp = bj; bus.stall = st;
        bus.branch_target = bt; bus.jump_target = jt;
        seq = m_pc + 16'd2;
        if (!m_halted) begin
            if (h) begin
                m_halted = 1'b1;
                m_instr = 16'h0000; m_pc2 = 16'h0000; m_valid = 1'b0;
            end else if (po) begin
                m_pc = {(bj ? bt[15:1] : jt[15:1]), 1'b0};
                m_instr = 16'h0000; m_pc2 = 16'h0000; m_valid = 1'b0;
                m_cnt = m_cnt + 16'd1;
            end else if (fl) begin
                m_pc = seq;
                m_instr = 16'h0000; m_pc2 = 16'h0000; m_valid = 1'b0;
            end else if (!st) begin
                m_instr = imem_f(m_pc);
                m_pc2 = seq; m_pc = seq; m_valid = 1'b1;
            end
        end
        e.pc = m_pc; e.instr = m_instr; e.pc2 = m_pc2; e.cnt = m_cnt;
        e.valid = m_valid; e.halted = m_halted;
        sb_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle_step();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    endtask

    task automatic jump_to(input logic [15:0] t);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, t);
    endtask

    task automatic check_reset_values(input string nm);
        chk({nm, ".pc"}, bus.imem_addr, 16'h0000);
        chk({nm, ".instr"}, bus.if_id_instr, 16'h0000);
        chk({nm, ".pc2"}, bus.if_id_pc2, 16'h0000);
        chk({nm, ".valid"}, {15'd0, bus.if_id_valid}, 16'h0000);
        chk({nm, ".halted"}, {15'd0, bus.halted}, 16'h0000);
`ifdef FETCH_REDIRECT_COUNT_EN
        chk({nm, ".cnt"}, bus.redirect_count, 16'h0000);
`endif
    endtask

    // Called at a negedge; asserts reset mid low phase and checks before the next posedge.
    task automatic reset_pulse();
        #2 reset = 1'b1;
        sb_q.delete();
        model_reset();
        halted_cycles = 0;
        #1 check_reset_values("async_reset");
        set_idle();
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Monitor: every post-edge view is compared against the oldest prediction.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("imem_addr", bus.imem_addr, e.pc);
                chk("if_id_instr", bus.if_id_instr, e.instr);
                chk("if_id_pc2", bus.if_id_pc2, e.pc2);
                chk("if_id_valid", {15'd0, bus.if_id_valid}, {15'd0, e.valid});
                chk("halted", {15'd0, bus.halted}, {15'd0, e.halted});
`ifdef FETCH_REDIRECT_COUNT_EN
                chk("redirect_count", bus.redirect_count, e.cnt);
`endif
            end
        end
    end

    initial begin
        total = 0;
        bad = 0;
        halted_cycles = 0;
        set_idle();
        model_reset();
        reset = 1'b1;
        #3 check_reset_values("initial_reset");
        @(negedge clk);
        reset = 1'b0;

        // First fetch from address 0.
        idle_step();
        // Stall holds at 0x0010, then resumes.
        jump_to(16'h0010);
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000);
        idle_step();
        // Branch redirect wins over stall, bit 0 cleared.
        jump_to(16'h0020);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0041, 16'h0777);
        idle_step();
        // Flush without redirect, then asynchronous reset.
        jump_to(16'h0008);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        reset_pulse();
        idle_step();
        // PC wrap.
        jump_to(16'hFFFE);
        idle_step();
        idle_step();
        // Halt wins over everything; HALTED ignores later redirects.
        jump_to(16'h0030);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0100);
        repeat (3) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0200, 16'h0300);
        reset_pulse();
        idle_step();

        // Randomised traffic.
        for (int i = 0; i < 2000; i++) begin
            logic h, fl, po, bj, st;
            h  = ($urandom_range(63) == 0);
            po = ($urandom_range(5) == 0);
            fl = ($urandom_range(5) == 0);
            st = ($urandom_range(3) == 0);
            bj = $urandom_range(1);
            step(h, fl, po, bj, st, 16'($urandom), 16'($urandom));
            if (m_halted) halted_cycles++;
            if (halted_cycles > 4 || $urandom_range(199) == 0) reset_pulse();
        end

        idle_step();
        idle_step();
        @(posedge clk);
        #2;
        chk("scoreboard_drained", 16'(sb_q.size()), 16'h0000);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
